// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: opcodes, FSM
// states, datapath mux encodings and the control output bundle.
package cpu_ctrl_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_LUI, S_AUIPC, S_ALUWB, S_BRANCH,
        S_JALRADR, S_JUMP, S_HALT
    } state_t;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_CMP  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic       instr_done;
    } ctrl_out_t;

    // State that follows DECODE for a given opcode
    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_RTYPE:          return S_EXECUTER;
            OP_ITYPE:          return S_EXECUTEI;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return S_JUMP;
            OP_JALR:           return S_JALRADR;
            OP_LUI:            return S_LUI;
            OP_AUIPC:          return S_AUIPC;
            default:           return S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational output decoder: state (plus op and mem_ready where a state
// needs them) to the datapath control bundle.
module ctrl_outdec
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output ctrl_out_t  ctrl
);

    // Moore decode; only FETCH and MEMWRITE look at mem_ready
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURES;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_update  = mem_ready;
            end
            S_DECODE: begin
                // precompute OldPC+imm so branch/JAL targets sit in ALUOut
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_RDATA;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_I;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            S_LUI: begin
                ctrl.alu_src_a = SRCA_ZERO;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_U;
            end
            S_AUIPC: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_U;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_CMP;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JALRADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_I;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_JUMP: begin
                // PC <- ALUOut (target); ALU forms OldPC+4 as the link value
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: state register, next-state logic, reset
// gating of the control outputs and the sticky illegal-opcode flag.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal
);

    state_t    state, state_n;
    logic      illegal_q;
    ctrl_out_t dec, ctrl;

    // Next state; op matters only in DECODE and MEMADR
    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:    if (mem_ready) state_n = S_DECODE;
            S_DECODE:   state_n = decode_next(op);
            S_MEMADR:   state_n = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_n = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_n = S_FETCH;
            S_MEMWB, S_ALUWB, S_BRANCH: state_n = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_LUI, S_AUIPC: state_n = S_ALUWB;
            S_JALRADR:  state_n = S_JUMP;
            S_JUMP:     state_n = S_ALUWB;
            S_HALT:     state_n = S_HALT;
            default:    state_n = S_HALT;
        endcase
    end

    // State register and sticky illegal flag; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n == S_HALT) illegal_q <= 1'b1;
        end
    end

    ctrl_outdec u_outdec (
        .state     (state),
        .op        (op),
        .mem_ready (mem_ready),
        .ctrl      (dec)
    );

    // Force every control line low while reset is held
    assign ctrl = rst ? '0 : dec;

    assign MemReq     = ctrl.mem_req;
    assign MemWrite   = ctrl.mem_write;
    assign AdrSrc     = ctrl.adr_src;
    assign IRWrite    = ctrl.ir_write;
    assign PCUpdate   = ctrl.pc_update;
    assign Branch     = ctrl.branch;
    assign RegWrite   = ctrl.reg_write;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUOp      = ctrl.alu_op;
    assign ResultSrc  = ctrl.result_src;
    assign ImmSrc     = ctrl.imm_src;
    assign instr_done = ctrl.instr_done;
    assign illegal    = illegal_q & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle streams built
// from the instruction-class rules, a latency table, random instruction mix
// with random wait states, plus halt and reset corner sequences.
module tb_multicycle_ctrl;

    localparam logic [6:0] O_LW  = 7'b0000011, O_SW  = 7'b0100011,
                           O_R   = 7'b0110011, O_I   = 7'b0010011,
                           O_BR  = 7'b1100011, O_JAL = 7'b1101111,
                           O_JR  = 7'b1100111, O_LUI = 7'b0110111,
                           O_AUI = 7'b0010111;

    logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
    logic [6:0] op = '0;
    logic MemReq, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [2:0] ImmSrc;
    logic instr_done, illegal;

    int checks = 0, failures = 0;

    typedef struct { bit rdy; logic [19:0] exp; } step_t;
    typedef struct { logic [6:0] op; int fw; int mw; int lat; } vec_t;
    step_t q[$];
    vec_t  tbl[10];

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    wire [19:0] act = {MemReq, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch,
                       RegWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc,
                       instr_done, illegal};

    function automatic logic [19:0] mk(input bit mr, mwr, ad, ir, pc, br, rw,
                                       input int sa, sb, ao, rs, im,
                                       input bit dn, il);
        return {mr, mwr, ad, ir, pc, br, rw, 2'(sa), 2'(sb), 2'(ao), 2'(rs),
                3'(im), dn, il};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
        end
    endtask

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle stream for one instruction with fw fetch waits and
    // mw memory waits; non-memory cycles get random (ignored) mem_ready.
    task automatic build(input logic [6:0] o, input int fw, input int mw);
        logic [19:0] aluwb = mk(0,0,0,0,0,0,1, 0,0,0,0,0, 1,0);
        logic [19:0] jump  = mk(0,0,0,0,1,0,0, 1,2,0,0,0, 0,0);
        for (int i = 0; i < fw; i++)
            q.push_back('{1'b0, mk(1,0,0,0,0,0,0, 0,2,0,2,0, 0,0)});
        q.push_back('{1'b1, mk(1,0,0,1,1,0,0, 0,2,0,2,0, 0,0)});
        q.push_back('{rnd(), mk(0,0,0,0,0,0,0, 1,1,0,0, (o == O_JAL) ? 3 : 2, 0,0)});
        case (o)
            O_LW: begin
                q.push_back('{rnd(), mk(0,0,0,0,0,0,0, 2,1,0,0,0, 0,0)});
                for (int i = 0; i <= mw; i++)
                    q.push_back('{(i == mw), mk(1,0,1,0,0,0,0, 0,0,0,0,0, 0,0)});
                q.push_back('{rnd(), mk(0,0,0,0,0,0,1, 0,0,0,1,0, 1,0)});
            end
            O_SW: begin
                q.push_back('{rnd(), mk(0,0,0,0,0,0,0, 2,1,0,0,1, 0,0)});
                for (int i = 0; i <= mw; i++)
                    q.push_back('{(i == mw), mk(1,1,1,0,0,0,0, 0,0,0,0,0, (i == mw),0)});
            end
            O_R:   begin q.push_back('{rnd(), mk(0,0,0,0,0,0,0, 2,0,2,0,0, 0,0)}); q.push_back('{rnd(), aluwb}); end
            O_I:   begin q.push_back('{rnd(), mk(0,0,0,0,0,0,0, 2,1,2,0,0, 0,0)}); q.push_back('{rnd(), aluwb}); end
            O_LUI: begin q.push_back('{rnd(), mk(0,0,0,0,0,0,0, 3,1,0,0,4, 0,0)}); q.push_back('{rnd(), aluwb}); end
            O_AUI: begin q.push_back('{rnd(), mk(0,0,0,0,0,0,0, 1,1,0,0,4, 0,0)}); q.push_back('{rnd(), aluwb}); end
            O_BR:    q.push_back('{rnd(), mk(0,0,0,0,0,1,0, 2,0,1,0,0, 1,0)});
            O_JAL: begin q.push_back('{rnd(), jump}); q.push_back('{rnd(), aluwb}); end
            O_JR: begin
                q.push_back('{rnd(), mk(0,0,0,0,0,0,0, 2,1,0,0,0, 0,0)});
                q.push_back('{rnd(), jump});
                q.push_back('{rnd(), aluwb});
            end
            default:
                for (int i = 0; i < 12; i++)
                    q.push_back('{rnd(), mk(0,0,0,0,0,0,0, 0,0,0,0,0, 0,1)});
        endcase
    endtask

    // Apply up to n queued steps (n<0: all); lat = cycle of first instr_done
    task automatic run(input logic [6:0] o, input int n, input string nm, output int lat);
        int i = 0;
        lat = -1;
        op = o;
        while (q.size() > 0 && (n < 0 || i < n)) begin
            step_t s = q.pop_front();
            mem_ready = s.rdy;
            @(negedge clk);
            chk($sformatf("%s_cyc%0d", nm, i + 1), 32'(act), 32'(s.exp));
            chk("pc_branch_excl", 32'(PCUpdate & Branch), 0);
            chk("regw_memreq_excl", 32'(RegWrite & MemReq), 0);
            if (instr_done && lat < 0) lat = i + 1;
            @(posedge clk); #1;
            i++;
        end
        q.delete();
    endtask

    initial begin
        int lat;
        tbl[0] = '{O_I,   0, 0, 4};  // addi
        tbl[1] = '{O_LW,  0, 2, 5};  // lw, two MEMREAD waits
        tbl[2] = '{O_SW,  0, 0, 4};
        tbl[3] = '{O_BR,  0, 0, 3};
        tbl[4] = '{O_JR,  0, 0, 5};
        tbl[5] = '{O_JAL, 0, 0, 4};
        tbl[6] = '{O_R,   1, 0, 4};
        tbl[7] = '{O_LUI, 2, 0, 4};
        tbl[8] = '{O_AUI, 0, 0, 4};
        tbl[9] = '{O_SW,  1, 3, 4};

        // reset: all outputs low while rst held, even with mem_ready high
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", 32'(act), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[k]) begin
            build(tbl[k].op, tbl[k].fw, tbl[k].mw);
            run(tbl[k].op, -1, $sformatf("vec%0d", k), lat);
            chk($sformatf("vec%0d_latency", k), 32'(lat), 32'(tbl[k].lat + tbl[k].fw + tbl[k].mw));
        end

        // random legal instruction mix with random wait states
        for (int k = 0; k < 40; k++) begin
            logic [6:0] ops [9];
            logic [6:0] o;
            ops = '{O_LW, O_SW, O_R, O_I, O_BR, O_JAL, O_JR, O_LUI, O_AUI};
            o = ops[$urandom_range(0, 8)];
            build(o, $urandom_range(0, 3), $urandom_range(0, 3));
            run(o, -1, $sformatf("rnd%0d", k), lat);
        end

        // illegal opcode parks in HALT with illegal held
        build(7'b0000000, 0, 0);
        run(7'b0000000, -1, "halt", lat);

        // reset pulse leaves HALT: first cycle is FETCH, illegal clear
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.push_back('{1'b0, mk(1,0,0,0,0,0,0, 0,2,0,2,0, 0,0)});
        q.push_back('{1'b0, mk(1,0,0,0,0,0,0, 0,2,0,2,0, 0,0)});
        run(O_I, -1, "after_halt_reset", lat);
        build(O_I, 0, 0);
        run(O_I, -1, "addi_after_reset", lat);
        chk("addi_after_reset_latency", 32'(lat), 4);

        // reset during a MEMREAD wait aborts the load without writeback
        build(O_LW, 0, 3);
        run(O_LW, 4, "lw_abort", lat);
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("abort_reset_outputs", 32'(act), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            q.push_back('{1'b0, mk(1,0,0,0,0,0,0, 0,2,0,2,0, 0,0)});
        run(O_LW, -1, "abort_refetch", lat);
        chk("abort_no_retire", 32'(lat), 32'(-1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
